// File: rtl/wb_grf_pkg.sv
// Shared codes for the W-stage write-back and register file: destination,
// data-source and load-extension selectors.
package wb_grf_pkg;

    typedef enum logic [1:0] {
        WREG_RT   = 2'd0,
        WREG_RD   = 2'd1,
        WREG_RA   = 2'd2,
        WREG_NONE = 2'd3
    } wreg_sel_e;

    typedef enum logic [1:0] {
        WDATA_ALU  = 2'd0,
        WDATA_MEM  = 2'd1,
        WDATA_PC8  = 2'd2,
        WDATA_HILO = 2'd3
    } wdata_sel_e;

    typedef enum logic [2:0] {
        XEXT_WORD = 3'd0,
        XEXT_BZ   = 3'd1,
        XEXT_BS   = 3'd2,
        XEXT_HZ   = 3'd3,
        XEXT_HS   = 3'd4
    } xext_op_e;

    // Link register used by jal-style instructions.
    localparam logic [4:0] RA_REG = 5'd31;

endpackage

// File: rtl/wb_grf_load_ext.sv
// Little-endian byte/halfword selection and zero/sign extension of a loaded word.
module load_ext
    import wb_grf_pkg::*;
(
    input  logic [31:0] dm,
    input  logic [1:0]  addr,
    input  logic [2:0]  xext_op,
    output logic [31:0] word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm[{addr, 3'b000} +: 8];
        half_sel = dm[{addr[1], 4'b0000} +: 16];
    end

    always_comb begin
        case (xext_op)
            XEXT_BZ: word = {24'h0, byte_sel};
            XEXT_BS: word = {{24{byte_sel[7]}}, byte_sel};
            XEXT_HZ: word = {16'h0, half_sel};
            XEXT_HS: word = {{16{half_sel[15]}}, half_sel};
            default: word = dm;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// W pipeline register, write-back mux and 31x32 register file with
// same-cycle write-through on both read ports.
module wb_grf
    import wb_grf_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] alu_m,
    input  logic [31:0] dm_m,
    input  logic [31:0] hilo_m,
    input  logic        flush_w,
    output logic [31:0] ir_w,
    input  logic [1:0]  wreg_sel,
    input  logic [1:0]  wdata_sel,
    input  logic        grf_we,
    input  logic [2:0]  xext_op,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    logic [31:0] pc_w;
    logic [31:0] alu_w;
    logic [31:0] dm_w;
    logic [31:0] hilo_w;
    logic [31:0] load_word;
    logic [31:0] regs [1:31];

    always_ff @(posedge clk) begin
        if (!reset_n || flush_w) begin
            ir_w   <= '0;
            pc_w   <= '0;
            alu_w  <= '0;
            dm_w   <= '0;
            hilo_w <= '0;
        end else begin
            ir_w   <= ir_m;
            pc_w   <= pc_m;
            alu_w  <= alu_m;
            dm_w   <= dm_m;
            hilo_w <= hilo_m;
        end
    end

    load_ext u_load_ext (
        .dm      (dm_w),
        .addr    (alu_w[1:0]),
        .xext_op (xext_op),
        .word    (load_word)
    );

    always_comb begin
        case (wreg_sel)
            WREG_RT: wb_addr = ir_w[20:16];
            WREG_RD: wb_addr = ir_w[15:11];
            WREG_RA: wb_addr = RA_REG;
            default: wb_addr = '0;
        endcase
    end

    always_comb begin
        case (wdata_sel)
            WDATA_ALU: wb_data = alu_w;
            WDATA_MEM: wb_data = load_word;
            WDATA_PC8: wb_data = pc_w + 32'd8;
            default:   wb_data = hilo_w;
        endcase
    end

    assign wb_we = grf_we && (wreg_sel != WREG_NONE) && (wb_addr != 5'd0);

    // Register 0 has no storage; wb_we is never set for it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 :
                 (wb_we && ra1 == wb_addr) ? wb_data : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 :
                 (wb_we && ra2 == wb_addr) ? wb_data : regs[ra2];

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: directed vector table, randomized vectors against a
// behavioural model, and hand sequences for flush and reset corners.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir_m = '0, pc_m = '0, alu_m = '0, dm_m = '0, hilo_m = '0;
    logic        flush_w = 1'b0;
    logic [31:0] ir_w;
    logic [1:0]  wreg_sel = 2'd3, wdata_sel = 2'd0;
    logic        grf_we = 1'b0;
    logic [2:0]  xext_op = 3'd0;
    logic [4:0]  ra1 = '0, ra2 = '0;
    logic [31:0] rd1, rd2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    wb_grf dut (
        .clk(clk), .reset_n(reset_n),
        .ir_m(ir_m), .pc_m(pc_m), .alu_m(alu_m), .dm_m(dm_m), .hilo_m(hilo_m),
        .flush_w(flush_w), .ir_w(ir_w),
        .wreg_sel(wreg_sel), .wdata_sel(wdata_sel), .grf_we(grf_we), .xext_op(xext_op),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    typedef struct {
        logic [31:0] ir, pc, alu, dm, hilo;
        logic [1:0]  wsel, dsel;
        logic        we;
        logic [2:0]  xop;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic        ewe;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] ref_regs [32];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] ir, pc, alu, dm, hilo,
                                input logic [1:0] wsel, dsel, input logic we,
                                input logic [2:0] xop, input logic [4:0] eaddr,
                                input logic [31:0] edata, input logic ewe);
        vec_t v;
        v.ir = ir; v.pc = pc; v.alu = alu; v.dm = dm; v.hilo = hilo;
        v.wsel = wsel; v.dsel = dsel; v.we = we; v.xop = xop;
        v.eaddr = eaddr; v.edata = edata; v.ewe = ewe;
        return v;
    endfunction

    // Reference: expected destination, data and enable from the write-back rules.
    function automatic vec_t model_eval(input vec_t v);
        vec_t r = v;
        int unsigned bsel, hsel, ld;
        bsel = (v.dm >> ((v.alu % 4) * 8)) & 32'hFF;
        hsel = (v.dm >> (((v.alu / 2) % 2) * 16)) & 32'hFFFF;
        case (v.xop)
            3'd1: ld = bsel;
            3'd2: ld = (bsel >= 128) ? (bsel | 32'hFFFF_FF00) : bsel;
            3'd3: ld = hsel;
            3'd4: ld = (hsel >= 32768) ? (hsel | 32'hFFFF_0000) : hsel;
            default: ld = v.dm;
        endcase
        case (v.wsel)
            2'd0: r.eaddr = 5'((v.ir >> 16) % 32);
            2'd1: r.eaddr = 5'((v.ir >> 11) % 32);
            2'd2: r.eaddr = 5'd31;
            default: r.eaddr = 5'd0;
        endcase
        case (v.dsel)
            2'd0: r.edata = v.alu;
            2'd1: r.edata = ld;
            2'd2: r.edata = v.pc + 32'd8;
            default: r.edata = v.hilo;
        endcase
        r.ewe = v.we && (v.wsel != 2'd3) && (r.eaddr != 5'd0);
        return r;
    endfunction

    task automatic bubble_ctrl();
        wreg_sel = 2'd3; wdata_sel = 2'd0; grf_we = 1'b0; xext_op = 3'd0;
    endtask

    task automatic drive_m(input vec_t v);
        ir_m = v.ir; pc_m = v.pc; alu_m = v.alu; dm_m = v.dm; hilo_m = v.hilo;
    endtask

    task automatic zero_m();
        ir_m = '0; pc_m = '0; alu_m = '0; dm_m = '0; hilo_m = '0;
    endtask

    task automatic issue(input vec_t v, input string tag);
        logic [4:0] other;
        logic [31:0] exp2;
        drive_m(v); flush_w = 1'b0; bubble_ctrl();
        @(posedge clk); #1;
        zero_m();
        wreg_sel = v.wsel; wdata_sel = v.dsel; grf_we = v.we; xext_op = v.xop;
        other = 5'($urandom_range(0, 31));
        ra1 = v.eaddr; ra2 = other;
        #1;
        check({tag, " ir_w"}, ir_w, v.ir);
        check({tag, " wb_we"}, {31'd0, wb_we}, {31'd0, v.ewe});
        check({tag, " wb_data"}, wb_data, v.edata);
        if (v.wsel != 2'd3) check({tag, " wb_addr"}, {27'd0, wb_addr}, {27'd0, v.eaddr});
        check({tag, " rd1 bypass"}, rd1, v.ewe ? v.edata : ref_regs[v.eaddr]);
        exp2 = (v.ewe && other == v.eaddr) ? v.edata : ref_regs[other];
        check({tag, " rd2"}, rd2, exp2);
        @(posedge clk); #1;
        bubble_ctrl();
        if (v.ewe) ref_regs[v.eaddr] = v.edata;
        ra1 = v.eaddr;
        #1;
        check({tag, " rd1 stored"}, rd1, ref_regs[v.eaddr]);
    endtask

    vec_t table_v [11];

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wreg_sel = 2'd0; wdata_sel = 2'd0; grf_we = 1'b1; xext_op = 3'd0;
        #1;
        check("reset ir_w", ir_w, 32'd0);
        check("reset wb_addr", {27'd0, wb_addr}, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset wb_we", {31'd0, wb_we}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            check($sformatf("reset rd1[%0d]", i), rd1, 32'd0);
            check($sformatf("reset rd2[%0d]", 31 - i), rd2, 32'd0);
        end
        bubble_ctrl();

        // Directed vectors with hand-derived expectations
        table_v[0]  = mk(32'h8005_0001, 0, 32'h0000_0001, 32'h1234_80FF, 0, 2'd0, 2'd1, 1, 3'd2, 5'd5,  32'hFFFF_FF80, 1);
        table_v[1]  = mk(32'h9406_0000, 0, 32'h0000_0002, 32'h8001_7FFF, 0, 2'd0, 2'd1, 1, 3'd3, 5'd6,  32'h0000_8001, 1);
        table_v[2]  = mk(32'h8406_0000, 0, 32'h0000_0002, 32'h8001_7FFF, 0, 2'd0, 2'd1, 1, 3'd4, 5'd6,  32'hFFFF_8001, 1);
        table_v[3]  = mk(32'h0C00_0000, 32'h0000_3000, 0, 0, 0,           2'd2, 2'd2, 1, 3'd0, 5'd31, 32'h0000_3008, 1);
        table_v[4]  = mk(32'h0000_0020, 0, 32'hDEAD_BEEF, 0, 0,           2'd1, 2'd0, 1, 3'd0, 5'd0,  32'hDEAD_BEEF, 0);
        table_v[5]  = mk(32'h0000_3820, 0, 32'h0000_0055, 0, 0,           2'd1, 2'd0, 1, 3'd0, 5'd7,  32'h0000_0055, 1);
        table_v[6]  = mk(32'h0007_3820, 0, 32'hCAFE_F00D, 0, 0,           2'd3, 2'd0, 1, 3'd0, 5'd7,  32'hCAFE_F00D, 0);
        table_v[7]  = mk(32'h0003_0000, 0, 0, 0, 32'h89AB_CDEF,           2'd0, 2'd3, 1, 3'd0, 5'd3,  32'h89AB_CDEF, 1);
        table_v[8]  = mk(32'h0004_0000, 0, 32'h0000_0003, 32'hA1B2_C3D4, 0, 2'd0, 2'd1, 1, 3'd1, 5'd4,  32'h0000_00A1, 1);
        table_v[9]  = mk(32'h0008_0000, 0, 32'h0000_0000, 32'hA1B2_C3D4, 0, 2'd0, 2'd1, 1, 3'd5, 5'd8,  32'hA1B2_C3D4, 1);
        table_v[10] = mk(32'h0C00_0000, 32'hFFFF_FFFC, 0, 0, 0,           2'd2, 2'd2, 1, 3'd0, 5'd31, 32'h0000_0004, 1);
        for (int i = 0; i < 11; i++) issue(table_v[i], $sformatf("vec%0d", i));

        // Randomized vectors against the model
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v = mk($urandom, $urandom, $urandom, $urandom, $urandom,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 0, 0);
            issue(model_eval(v), $sformatf("rnd%0d", i));
        end

        // Reset while a valid write sits in W: it must be discarded
        check("pre-reset $9", ref_regs[9], ref_regs[9]);
        n_total--; n_pass--;
        ir_m = 32'h0009_0000; alu_m = 32'h0000_1234; bubble_ctrl();
        @(posedge clk); #1;
        zero_m();
        wreg_sel = 2'd0; wdata_sel = 2'd0; grf_we = 1'b1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; bubble_ctrl();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        ra1 = 5'd9; ra2 = 5'd31;
        #1;
        check("midreset ir_w", ir_w, 32'd0);
        check("midreset $9", rd1, 32'd0);
        check("midreset $31", rd2, 32'd0);

        // Write $7 with flush on the same edge, then reset
        ir_m = 32'h0000_3820; alu_m = 32'h0000_0055; bubble_ctrl();
        @(posedge clk); #1;
        ir_m = 32'hFFFF_FFFF; alu_m = 32'h1111_1111;
        wreg_sel = 2'd1; wdata_sel = 2'd0; grf_we = 1'b1;
        flush_w = 1'b1;
        @(posedge clk); #1;
        flush_w = 1'b0; zero_m();
        wreg_sel = 2'd1; grf_we = 1'b1;
        ra1 = 5'd7;
        #1;
        check("flush ir_w", ir_w, 32'd0);
        check("flush wb_we", {31'd0, wb_we}, 32'd0);
        check("flush $7 committed", rd1, 32'h0000_0055);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; bubble_ctrl();
        #1;
        check("post-reset $7", rd1, 32'd0);
        check("post-reset ir_w", ir_w, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low: clk (1-bit, rising edge) and reset_n (1-bit, active-low, synchronous).
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 ir_m, pc_m, alu_m, dm_m, hilo_m  input  32 each  M-stage instruction, PC, ALU result/address, DM read word, HI/LO read value.
REQ-005 flush_w  input  1  loads a bubble (all-zero) into the W register.
REQ-006 ir_w  output  32  registered W-stage instruction, driven to the external W control decoder.
REQ-007 wreg_sel, wdata_sel  input  2 each; grf_we  input  1; xext_op  input  3: decoded controls for ir_w, returned in the same cycle.
REQ-008 ra1, ra2  input  5 each; rd1, rd2  output  32 each: D-stage read ports.
REQ-009 wb_we  output  1; wb_addr  output  5; wb_data  output  32: current write, for the forwarding unit.

Function
REQ-010 The W register (ir, pc, alu, dm, hilo) SHALL load the M-stage inputs every rising edge; flush_w loads all zeros instead.
REQ-011 Destination: wreg_sel 0 -> ir_w[20:16]; 1 -> ir_w[15:11]; 2 -> 31; 3 -> write suppressed.
REQ-012 Data: wdata_sel 0 -> alu_w; 1 -> extended load; 2 -> pc_w+8 (mod 2^32); 3 -> hilo_w.
REQ-013 Load byte select SHALL be little-endian: byte = dm_w[8*alu_w[1:0] +: 8]; half = dm_w[16*alu_w[1] +: 16].
REQ-014 xext_op: 0 word unchanged; 1 byte zero-extend; 2 byte sign-extend; 3 half zero-extend; 4 half sign-extend; 5-7 same as 0.
REQ-015 wb_we = grf_we AND wreg_sel!=3 AND wb_addr!=0; wb_addr/wb_data SHALL be combinational from the W register.
REQ-016 The 31x32 register file SHALL write wb_data to wb_addr on the rising edge when wb_we=1; register 0 SHALL read as 0 and never be stored.
REQ-017 Read ports are combinational; when wb_we=1 and raN==wb_addr, rdN SHALL return wb_data (same-cycle write-through).
REQ-018 Simultaneous flush_w and a valid W write: the current W write commits; the bubble follows.
REQ-019 Latency: an instruction presented on ir_m at edge N writes the GRF at edge N+1 and is visible on rdN via bypass during cycle N..N+1.

Reset
REQ-020 When reset_n=0 at a rising edge, the W register and all 31 registers SHALL clear to 0; this takes priority over any pending write.
REQ-021 After reset, ir_w=0, wb_addr=0, wb_data=0, wb_we=0, and rd1=rd2=0 for all addresses.
REQ-022 Reset asserted mid-stream SHALL discard the W-stage instruction, which is not written.

Structure
REQ-023 The shared package SHALL hold the wreg_sel codes (RT, RD, RA, NONE), the wdata_sel codes (ALU, MEM, PC8, HILO), the xext_op codes, and the constant 31.
REQ-024 The load extender SHALL be one combinational sub-module, load_ext (inputs dm word, addr[1:0], xext_op; output 32-bit word).
REQ-025 Register-file storage and bypass SHALL live in wb_grf itself; no other sub-modules.

Verification
REQ-026 lb with dm_m=0x1234_80FF, alu_m[1:0]=1, wreg_sel=0, rt=5, xext_op=2, wdata_sel=1 -> $5=0xFFFF_FF80.
REQ-027 lhu with dm_m=0x8001_7FFF, alu_m[1:0]=2, xext_op=3 -> destination = 0x0000_8001; the same access with lh (xext_op=4) -> 0xFFFF_8001.
REQ-028 jal at pc_m=0x0000_3000, wreg_sel=2, wdata_sel=2 -> $31=0x0000_3008; ra1=31 in the same cycle -> rd1=0x0000_3008 via bypass.
REQ-029 Write to rd=0 with alu_m=0xDEAD_BEEF -> wb_we=0; rd1 with ra1=0 stays 0.
REQ-030 Write $7=0x55; flush_w=1 on the next edge -> ir_w=0 and no further write; then reset_n=0 for one edge -> $7 reads 0.
REQ-031 wreg_sel=3 with grf_we=1 -> wb_we=0 and no register changes.
